// File: rtl/xgriscv_muldiv.sv
// xgriscv_muldiv: iterative RV32M/RV64M multiply/divide unit.
// Shift-add multiplier and restoring divider, one bit per cycle, valid/ready
// on both sides, flush aborts in-flight work.
// Optional macro XGRISCV_DIV_EN: when defined the divider datapath is built;
// when undefined divide ops complete in one edge with out_err=1, result 0.
module xgriscv_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_err
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_a_q, neg_a_d;
  logic                neg_b_q, neg_b_d;
  // multiplicand for multiply, divisor for divide
  logic [XLEN-1:0]     mcand_q, mcand_d;
  // {high, low} product for multiply, {remainder, quotient} for divide
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic                err_q, err_d;

  // operand decode on the input side
  logic                op_sa, op_sb;
  logic                sgn_a, sgn_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                accept;

  // multiply step and correction
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     mul_res;

`ifdef XGRISCV_DIV_EN
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  logic                div0, ovf;
  logic [XLEN:0]       div_sh, div_diff;
  logic                div_ge;
  logic [2*XLEN-1:0]   div_next;
  logic [XLEN-1:0]     quot_fix, rem_fix, div_res;
`endif

  // input operand signedness and magnitudes
  always_comb begin
    op_sa  = (in_op == 3'b001) || (in_op == 3'b010) || (in_op == 3'b100) || (in_op == 3'b110);
    op_sb  = (in_op == 3'b001) || (in_op == 3'b100) || (in_op == 3'b110);
    sgn_a  = op_sa & in_a[XLEN-1];
    sgn_b  = op_sb & in_b[XLEN-1];
    mag_a  = sgn_a ? (~in_a + 1'b1) : in_a;
    mag_b  = sgn_b ? (~in_b + 1'b1) : in_b;
    accept = in_valid & ~flush;
  end

  // one shift-add multiply iteration and the final sign correction
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q + 1'b1) : acc_q;
    mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

`ifdef XGRISCV_DIV_EN
  // special-case detection, one restoring-divide iteration, sign correction
  always_comb begin
    div0     = (in_b == '0);
    ovf      = ((in_op == 3'b100) || (in_op == 3'b110)) && (in_a == SMIN) && (in_b == '1);
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_sh - {1'b0, mcand_q};
    div_ge   = ~div_diff[XLEN];
    div_next = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    quot_fix = (neg_a_q ^ neg_b_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = neg_a_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    div_res  = op_q[1] ? rem_fix : quot_fix;
  end
`endif

  // next-state, datapath next values and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    res_d     = res_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          op_d    = in_op;
          neg_a_d = sgn_a;
          neg_b_d = sgn_b;
          cnt_d   = CW'(XLEN - 1);
          err_d   = 1'b0;
          if (in_op[2]) begin
`ifdef XGRISCV_DIV_EN
            if (div0) begin
              res_d   = in_op[1] ? in_a : '1;
              state_d = S_DONE;
            end else if (ovf) begin
              res_d   = in_op[1] ? '0 : in_a;
              state_d = S_DONE;
            end else begin
              mcand_d = mag_b;
              acc_d   = {{XLEN{1'b0}}, mag_a};
              state_d = S_RUN;
            end
`else
            res_d   = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
`endif
          end else begin
            mcand_d = mag_a;
            acc_d   = {{XLEN{1'b0}}, mag_b};
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        busy = 1'b1;
`ifdef XGRISCV_DIV_EN
        acc_d = op_q[2] ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        busy = 1'b1;
`ifdef XGRISCV_DIV_EN
        res_d = op_q[2] ? div_res : mul_res;
`else
        res_d = mul_res;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // result is forced to zero outside DONE so consumers never see stale data
  always_comb begin
    out_result = out_valid ? res_q : '0;
    out_err    = out_valid & err_q;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      op_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/xgriscv_muldiv.md
# xgriscv_muldiv

Iterative RV32M/RV64M multiply/divide unit for the xgriscv core. It sits beside the combinational `alu` in the execute stage. It accepts one operation at a time through a valid/ready handshake and computes the result over multiple cycles with a shift-add multiplier or a restoring divider. It holds the result until the pipeline consumes it. A flush input discards in-flight work on redirects and traps.

## Interface
- `XLEN`, 32: operand and result width; legal values are 32 and 64.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rstn` input 1: asynchronous active-low reset.
- `in_valid` input 1: an operation is presented.
- `in_ready` output 1: unit can accept an operation; high only in IDLE.
- `in_op` input 3: RISC-V funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `in_a` input XLEN: rs1 operand.
- `in_b` input XLEN: rs2 operand.
- `flush` input 1: abort the current operation and return to IDLE.
- `busy` output 1: high in RUN and FIX.
- `out_valid` output 1: result available; high only in DONE.
- `out_ready` input 1: consumer takes the result.
- `out_result` output XLEN: result; 0 whenever `out_valid` is low.
- `out_err` output 1: unsupported op; qualified by `out_valid`.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: iterate.
  - FIX: sign correction.
  - DONE: hold result.
- Transitions:
  - IDLE→RUN when `in_valid`.
  - IDLE→DONE when `in_valid` and the op is a special-case divide.
  - RUN→FIX when the iteration counter reaches 0; the counter loads XLEN-1 on accept.
  - FIX→DONE unconditionally.
  - DONE→IDLE when `out_ready`.
- Accept latches operand magnitudes, per-operand negate flags, and the op.
  - MULH and DIV/REM take both operands as signed.
  - MULHSU takes only `in_a` as signed.
- Multiply:
  - 2·XLEN-bit product, one partial-product bit per RUN cycle.
  - FIX negates the product when exactly one negate flag is set.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- Divide:
  - Restoring divide, one quotient bit per RUN cycle.
  - FIX negates the quotient when the operand signs differ.
  - FIX gives the remainder the sign of the dividend.
- Special cases are decided in IDLE on accept and go directly to DONE:
  - Divide by zero: quotient = all ones; remainder = `in_a`.
  - Signed overflow (`in_a` = −2^(XLEN−1), `in_b` = −1): quotient = `in_a`; remainder = 0.
- `flush`:
  - Highest priority; moves any state to IDLE on the next edge.
  - Clears `out_valid` on that edge.
  - An `in_valid` in the same cycle as `flush` is not accepted.
- `in_a`/`in_b` changing after accept has no effect.

## Timing
- Reset values:
  - state = IDLE
  - `in_ready`=1
  - `busy`=0
  - `out_valid`=0
  - `out_result`=0
  - `out_err`=0
  - counter = 0
- Normal latency: `out_valid` rises XLEN+2 edges after the accepting edge (32-bit: 34).
- Special-case latency: `out_valid` rises 1 edge after the accepting edge.
- `out_result` and `out_err` are stable while `out_valid`=1 and `out_ready`=0.
- The earliest next accept is the cycle after the DONE→IDLE edge. There is no back-to-back accept in DONE.
- Reset asserted mid-operation forces the reset values immediately, without waiting for `clk`.

## Configuration
- `XGRISCV_DIV_EN` defined:
  - All eight ops are supported.
- `XGRISCV_DIV_EN` undefined:
  - Divider datapath is removed.
  - Ops 100–111 go IDLE→DONE in 1 edge with `out_result`=0 and `out_err`=1.
  - Multiply behaviour is unchanged.

## Test plan
- MUL, XLEN=32, a=0x0000_0007, b=0xFFFF_FFFD → after 34 edges `out_result`=0xFFFF_FFEB, `out_err`=0.
- MULH a=0x8000_0000, b=0x8000_0000 → 0x4000_0000.
- MULHU same operands → 0x4000_0000.
- MULHSU a=0xFFFF_FFFF, b=0xFFFF_FFFF → 0xFFFF_FFFF.
- DIV a=0xFFFF_FFF9 (−7), b=2 → 0xFFFF_FFFD.
- REM same operands → 0xFFFF_FFFF.
- DIVU a=0xFFFF_FFF9, b=2 → 0x7FFF_FFFC.
- Special cases: DIV a=5, b=0 → 0xFFFF_FFFF after 1 edge.
- Special cases: REM a=5, b=0 → 5.
- Special cases: DIV a=0x8000_0000, b=0xFFFF_FFFF → 0x8000_0000.
- Special cases: REM same operands → 0.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `out_valid` and `out_result` unchanged, `in_ready`=0; `out_ready`=1 → IDLE next edge.
- Abort: `flush` at RUN cycle 5 → IDLE next edge, `out_valid` never rises; a new MUL 3×4 then returns 12.
- Reset: deassert `rstn` mid-RUN → all outputs at reset values asynchronously.
- Compile without `XGRISCV_DIV_EN`: DIVU → 1-edge response, `out_err`=1, result 0; MUL 3×4 still returns 12.
